// File: rtl/spi_slave_ctrl_pkg.sv
// Shared types and helpers for the SPI slave memory-path controller.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_GET       = 3'd0,
      ST_GOT       = 3'd1,
      ST_RD_WAIT   = 3'd2,
      ST_RD_LOAD   = 3'd3,
      ST_RD_SHIFT  = 3'd4,
      ST_WR_SHIFT  = 3'd5,
      ST_WR_COMMIT = 3'd6,
      ST_DONE      = 3'd7
   } spi_state_e;

   localparam logic RW_READ = 1'b1;

   // Bit-counter width large enough to hold the longer of header and data phase.
   function automatic int cnt_width(input int hdr_len, input int data_len);
      int longest;
      longest = (hdr_len > data_len) ? hdr_len : data_len;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Strobe/handshake bundle between the SPI front end and the memory-path controller.
interface spi_slave_ctrl_if;

   logic cs_n;
   logic sclk_pos;
   logic sclk_neg;
   logic read_write;
   logic miso_buff;
   logic dm_we;
   logic ad_we;
   logic sr_we;
   logic addr_inc;
   logic busy;

   modport master (
      output cs_n, sclk_pos, sclk_neg, read_write,
      input  miso_buff, dm_we, ad_we, sr_we, addr_inc, busy
   );

   modport slave (
      input  cs_n, sclk_pos, sclk_neg, read_write,
      output miso_buff, dm_we, ad_we, sr_we, addr_inc, busy
   );

endinterface

// File: rtl/spi_slave_ctrl_bit_counter.sv
// Serial-edge counter shared by the header and data phases; flags the
// strobe that completes a phase and wraps to zero on that same edge.
module spi_bit_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] term_val,
   output logic         term_hit
);

   logic [W-1:0] count_q, count_d;

   // Terminal detect and next count; clear wins over counting.
   always_comb begin
      term_hit = en && !clear && (count_q == (term_val - W'(1)));
      count_d  = count_q;
      if (clear || term_hit) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave memory-path sequencer: header capture, read latency wait,
// shift-register load, MISO enable, data write and optional bursts.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_GET       | counting header bits (address then R/W)
// ST_GOT       | header complete, latch address (ad_we)
// ST_RD_WAIT   | waiting MEM_LAT clocks for read data
// ST_RD_LOAD   | parallel-load read data into shift register (sr_we)
// ST_RD_SHIFT  | shifting read data out, MISO driven
// ST_WR_SHIFT  | shifting write data in
// ST_WR_COMMIT | write word to memory (dm_we), addr_inc in burst mode
// ST_DONE      | transfer finished, idle until cs_n rises
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8,
   parameter int MEM_LAT = 1,
   parameter int BURST   = 0
) (
   input logic             clk,
   input logic             rst_n,
   spi_slave_ctrl_if.slave bus
);

   localparam int         HDR_LEN  = ADDR_W + 1;
   localparam int         CNT_W    = cnt_width(HDR_LEN, DATA_W);
   localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

   spi_state_e state_q, state_d;
   logic [2:0] lat_q, lat_d;
   logic       lat_done;

   logic             cnt_en;
   logic             cnt_hit;
   logic [CNT_W-1:0] cnt_term;

   logic miso_buff, dm_we, ad_we, sr_we, addr_inc, busy;

   // Only the shift states consume strobes; everything else ignores them.
   always_comb begin
      cnt_en   = 1'b0;
      cnt_term = CNT_W'(DATA_W);
      unique case (state_q)
         ST_GET: begin
            cnt_en   = bus.sclk_pos;
            cnt_term = CNT_W'(HDR_LEN);
         end
         ST_WR_SHIFT: cnt_en = bus.sclk_pos;
         ST_RD_SHIFT: cnt_en = bus.sclk_neg;
         default: ;
      endcase
   end

   spi_bit_counter #(.W(CNT_W)) u_bit_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.cs_n),
      .en       (cnt_en),
      .term_val (cnt_term),
      .term_hit (cnt_hit)
   );

   // Read-latency down-counter: reloaded outside RD_WAIT, expires at zero.
   always_comb begin
      lat_d    = (state_q == ST_RD_WAIT) ? (lat_q - 3'd1) : LAT_LOAD;
      lat_done = (lat_q == 3'd0);
   end

   // Next-state and output decode; cs_n high overrides the state logic.
   always_comb begin
      state_d   = state_q;
      miso_buff = 1'b0;
      dm_we     = 1'b0;
      ad_we     = 1'b0;
      sr_we     = 1'b0;
      addr_inc  = 1'b0;
      busy      = (state_q != ST_GET) && (state_q != ST_DONE);
      unique case (state_q)
         ST_GET: begin
            if (cnt_hit) state_d = ST_GOT;
         end
         ST_GOT: begin
            ad_we   = 1'b1;
            state_d = (bus.read_write == RW_READ) ? ST_RD_WAIT : ST_WR_SHIFT;
         end
         ST_RD_WAIT: begin
            if (lat_done) state_d = ST_RD_LOAD;
         end
         ST_RD_LOAD: begin
            sr_we   = 1'b1;
            state_d = ST_RD_SHIFT;
         end
         ST_RD_SHIFT: begin
            miso_buff = 1'b1;
            if (cnt_hit) begin
               if (BURST != 0) begin
                  // Bump the address on the last shift-out edge so the
                  // next word's memory access starts immediately.
                  addr_inc = 1'b1;
                  state_d  = ST_RD_WAIT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_WR_SHIFT: begin
            if (cnt_hit) state_d = ST_WR_COMMIT;
         end
         ST_WR_COMMIT: begin
            dm_we = 1'b1;
            if (BURST != 0) begin
               addr_inc = 1'b1;
               state_d  = ST_WR_SHIFT;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: ;
         default: state_d = ST_GET;
      endcase
      if (bus.cs_n) state_d = ST_GET;
   end

   // State and latency registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_GET;
         lat_q   <= LAT_LOAD;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
      end
   end

   assign bus.miso_buff = miso_buff;
   assign bus.dm_we     = dm_we;
   assign bus.ad_we     = ad_we;
   assign bus.sr_we     = sr_we;
   assign bus.addr_inc  = addr_inc;
   assign bus.busy      = busy;

endmodule
